array_multiplier_pipe: RTL and testbench
========================================

// Module: array_multiplier_pipe
// PURPOSE
//   Fully pipelined unsigned array multiplier: one partial-product row per stage.
//   Accepts a new operand pair every clock and returns the low `width` bits of a*b.
//   Used as a throughput-oriented multiply unit where long latency is acceptable.
// PARAMETERS
//   width  32  operand and result width in bits (>=2)
// PORTS
//   clk  in   1      clock; all state updates on the rising edge
//   rst  in   1      reset, synchronous, active-high
//   a    in   width  multiplicand, unsigned, sampled every rising edge
//   b    in   width  multiplier, unsigned, sampled every rising edge
//   y    out  width  product bits [width-1:0] of a*b, driven directly by the last stage register
// BEHAVIOUR
//   - One clock, clk; reset rst is synchronous and active-high.
//   - Pipeline has exactly `width` register stages, S0..S(width-1). There is no input register separate from S0.
//   - Each stage Sk holds three values:
//       - acc_k: width-bit partial sum
//       - a_k: operand a carried forward
//       - b_k: the not-yet-used bits of operand b, carried forward
//   - Edge capturing the pair (stage S0): acc0 = b[0] ? a : 0. a and b are captured alongside.
//   - Stage Sk, for k = 1..width-1:
//       - acc_k = acc_(k-1) + (b_(k-1)[k] ? (a_(k-1) << k) : 0)
//       - truncated to width bits (mod 2^width)
//   - y = acc of S(width-1).
//   - Latency: pair sampled at edge N. Then y = (a*b) mod 2^width from just after edge N+width-1
//     until edge N+width.
//   - Throughput: one result per cycle. Results emerge in issue order. There is no stall and no valid handshake.
//   - Operands need only be stable at their capturing edge. Later X/changes on a and b must not corrupt in-flight results.
//   - Arithmetic is unsigned. Overflow wraps; no overflow flag.
//   - Reset: while rst=1 at an edge, all stage registers are cleared to 0, and y=0 from the next cycle on.
//       - Operand pairs that are in flight are discarded.
//       - Reset has priority over capture.
//   - After rst is deasserted: the first sampled pair appears on y width-1 edges later. Until then y stays 0.
//   - No combinational path from a or b to y.
// TESTING
//   - Reset: rst=1 for 2 edges, then a=b=0 -> y=0 in every cycle.
//   - Basic: a=3, b=5 at edge N -> y=15 after edge N+31.
//       - y is never 15 earlier.
//       - Afterwards inputs are driven X.
//   - Wrap: a=32'hFFFFFFFF, b=32'hFFFFFFFF -> y=32'h00000001.
//       - a=32'h80000000, b=2 -> y=0.
//   - Random: 100 pairs from xorshift32 seeded 1.
//       - Issue each pair for one cycle, then drive X for 31 cycles.
//       - Each result must be y === (a*b)[31:0] after edge N+31.
//   - Back-to-back: issue (1,1), (2,3), (7,9), (65535,65537) on consecutive edges.
//       - Expect y = 1, 6, 63, 32'hFFFFFFFF on consecutive cycles starting after edge N+31.
//   - Mid-flight reset: issue (5,6), then assert rst at edge N+10.
//       - y must stay 0. No 30 may appear.

Source files
------------

// File: rtl/array_multiplier_pipe.sv
// Fully pipelined unsigned array multiplier: one partial-product row per stage,
// `width` stages deep, returning the low `width` bits of a*b every clock.
module array_multiplier_pipe #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] y
);

    // r_b[k] keeps only the multiplier bits not yet consumed, right-aligned,
    // so bit 0 is always the bit the following stage needs.
    logic [width-1:0] r_acc [width];
    logic [width-1:0] r_a   [width-1];
    logic [width-1:0] r_b   [width-1];
    logic [width-1:0] w_pp  [1:width-1];

    for (genvar k = 1; k < width; k++) begin : g_pp
        assign w_pp[k] = r_b[k-1][0] ? (r_a[k-1] << k) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < width; k++) begin
                r_acc[k] <= '0;
            end
            for (int k = 0; k < width - 1; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            r_acc[0] <= b[0] ? a : '0;
            r_a[0]   <= a;
            r_b[0]   <= b >> 1;
            for (int k = 1; k < width; k++) begin
                r_acc[k] <= r_acc[k-1] + w_pp[k];
            end
            // The last stage needs only the accumulator; operands stop one stage earlier.
            for (int k = 1; k < width - 1; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1] >> 1;
            end
        end
    end

    assign y = r_acc[width-1];

endmodule

// File: tb/tb_array_multiplier_pipe.sv
// Self-checking bench for array_multiplier_pipe (width 32): directed cases plus
// xorshift32-driven random pairs checked against a plain-arithmetic product model.
module tb_array_multiplier_pipe;

    localparam int W   = 32;
    localparam int LAT = W - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] xs_state;

    array_multiplier_pipe #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .y   (y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_mul(input logic [31:0] ma, input logic [31:0] mb);
        logic [63:0] full;
        full = 64'(ma) * 64'(mb);
        return full[31:0];
    endfunction

    function automatic logic [31:0] xorshift32_next();
        logic [31:0] x;
        x = xs_state;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        xs_state = x;
        return x;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a = '0;
        b = '0;
        tick();
        n_checks++;
        if (y !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_first_edge y=%h expected=%h", y, 32'd0);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            tick();
            n_checks++;
            if (y !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_idle cycle=%0d y=%h expected=%h", i, y, 32'd0);
            end
        end
    endtask

    // Issue one pair, drive X afterwards, and require the product exactly at the
    // expected edge and nowhere earlier.
    task automatic test_single(input string name, input logic [31:0] ta, input logic [31:0] tb_op);
        logic [31:0] exp;
        exp = model_mul(ta, tb_op);
        a = ta;
        b = tb_op;
        tick();
        a = 'x;
        b = 'x;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                if (exp != 32'd0) begin
                    n_checks++;
                    if (y === exp) begin
                        n_errors++;
                        $display("FAIL %s_early edge=N+%0d y=%h must_not_be=%h", name, i, y, exp);
                    end
                end
            end else begin
                n_checks++;
                if (y !== exp) begin
                    n_errors++;
                    $display("FAIL %s_result y=%h expected=%h", name, y, exp);
                end
            end
        end
    endtask

    task automatic test_basic();
        test_single("basic", 32'd3, 32'd5);
    endtask

    task automatic test_wrap();
        test_single("wrap_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_single("wrap_msb", 32'h8000_0000, 32'd2);
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp;
        xs_state = 32'd1;
        for (int p = 0; p < 100; p++) begin
            ra = xorshift32_next();
            rb = xorshift32_next();
            exp = model_mul(ra, rb);
            a = ra;
            b = rb;
            tick();
            a = 'x;
            b = 'x;
            for (int i = 1; i <= LAT; i++) begin
                tick();
            end
            n_checks++;
            if (y !== exp) begin
                n_errors++;
                $display("FAIL random pair=%0d a=%h b=%h y=%h expected=%h", p, ra, rb, y, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa  [$];
        logic [31:0] qb  [$];
        logic [31:0] exp [$];
        qa = '{32'd1, 32'd2, 32'd7, 32'd65535};
        qb = '{32'd1, 32'd3, 32'd9, 32'd65537};
        for (int i = 0; i < qa.size(); i++) begin
            exp.push_back(model_mul(qa[i], qb[i]));
        end
        for (int e = 0; e < LAT + qa.size(); e++) begin
            if (e < qa.size()) begin
                a = qa[e];
                b = qb[e];
            end else begin
                a = 'x;
                b = 'x;
            end
            tick();
            if (e >= LAT) begin
                n_checks++;
                if (y !== exp[e-LAT]) begin
                    n_errors++;
                    $display("FAIL back_to_back idx=%0d y=%h expected=%h", e - LAT, y, exp[e-LAT]);
                end
            end
        end
    endtask

    task automatic test_midflight_reset();
        a = 32'd5;
        b = 32'd6;
        tick();
        a = 'x;
        b = 'x;
        for (int i = 1; i < 10; i++) begin
            tick();
            n_checks++;
            if (y === 32'd30) begin
                n_errors++;
                $display("FAIL midflight_pre_reset edge=N+%0d y=%h must_not_be=%h", i, y, 32'd30);
            end
        end
        rst = 1'b1;
        a = '0;
        b = '0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (y !== 32'd0) begin
            n_errors++;
            $display("FAIL midflight_reset_edge y=%h expected=%h", y, 32'd0);
        end
        for (int i = 0; i < W + 4; i++) begin
            tick();
            n_checks++;
            if (y !== 32'd0) begin
                n_errors++;
                $display("FAIL midflight_after cycle=%0d y=%h expected=%h", i, y, 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_back_to_back();
        test_midflight_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
